kart_drive_ctrl: RTL and testbench

//  Line-following drive sequencer; generates the 3-bit mode word consumed by the motor block.

---
 rtl/kart_drive_ctrl_pkg.sv | 33 +++
 rtl/kart_drive_ctrl_line_sensor_filter.sv | 51 +++++
 rtl/kart_drive_ctrl.sv | 113 +++++++++++
 tb/tb_kart_drive_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kart_drive_ctrl_pkg.sv
// Shared constants and types for the kart drive sequencer: motor mode words,
// FSM state encoding and the line-sensor decode helper.
package kart_drive_ctrl_pkg;

    localparam logic [2:0] MODE_STOP  = 3'b000;
    localparam logic [2:0] MODE_FWD   = 3'b001;
    localparam logic [2:0] MODE_LEFT  = 3'b010;
    localparam logic [2:0] MODE_RIGHT = 3'b011;
    localparam logic [2:0] MODE_REV   = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FOLLOW  = 3'd1,
        ST_SEARCH  = 3'd2,
        ST_BRAKE_R = 3'd3,
        ST_REVERSE = 3'd4,
        ST_BRAKE_F = 3'd5,
        ST_HALT    = 3'd6
    } state_t;

    // Filtered {left,mid,right} to motor mode; 000 (line lost) maps to stop.
    function automatic logic [2:0] decode_line(input logic [2:0] s);
        logic [2:0] m;
        case (s)
            3'b010, 3'b111, 3'b101: m = MODE_FWD;
            3'b100, 3'b110:         m = MODE_LEFT;
            3'b001, 3'b011:         m = MODE_RIGHT;
            default:                m = MODE_STOP;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/kart_drive_ctrl_line_sensor_filter.sv
// Two-flop synchroniser plus per-bit debounce: a filtered bit only follows
// its synchronised input after DEB_CYC consecutive differing samples.
module line_sensor_filter #(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned DEB_CYC = 100_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] filt_o
);

    localparam int unsigned CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] filt_q;
    logic [CW-1:0]    cnt_q [WIDTH];

    // Bring the asynchronous sensor pins into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive samples that disagree with the filtered value; flip after DEB_CYC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CW'(DEB_CYC - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/kart_drive_ctrl.sv
// Line-following drive sequencer: debounced sensor decode, lost-line search
// and reverse recovery with stop dead-time around every reverse phase.
module kart_drive_ctrl
    import kart_drive_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYC    = 100_000,
    parameter int unsigned DEAD_CYC   = 2_000_000,
    parameter int unsigned SEARCH_CYC = 50_000_000,
    parameter int unsigned REV_CYC    = 30_000_000,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [2:0] sensor,
    output logic [2:0] mode,
    output logic [2:0] state,
    output logic       halted
);

    localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);

    logic [2:0]  filt;
    logic [2:0]  line_mode;
    logic        line_present;

    state_t      state_q, state_d;
    logic [31:0] timer_q;
    logic [7:0]  retry_q, retry_d;
    logic [2:0]  last_turn_q, last_turn_d;
    logic [2:0]  mode_q, mode_d;
    logic        halted_q;

    line_sensor_filter #(
        .WIDTH   (3),
        .DEB_CYC (DEB_CYC)
    ) u_filter (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (sensor),
        .filt_o (filt)
    );

    // Next state, retry/last-turn bookkeeping and the mode word for this state.
    always_comb begin
        line_mode    = decode_line(filt);
        line_present = (filt != 3'b000);
        state_d      = state_q;
        retry_d      = retry_q;
        last_turn_d  = last_turn_q;
        mode_d       = MODE_STOP;
        if (!enable) begin
            state_d = ST_IDLE;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_FOLLOW;
                ST_FOLLOW: begin
                    mode_d = line_mode;
                    if (line_present) retry_d = '0;
                    if (line_mode == MODE_LEFT || line_mode == MODE_RIGHT) last_turn_d = line_mode;
                    if (!line_present) state_d = ST_SEARCH;
                end
                ST_SEARCH: begin
                    mode_d = last_turn_q;
                    if (line_present)
                        state_d = ST_FOLLOW;
                    else if (timer_q == SEARCH_CYC - 1)
                        state_d = (retry_q < RETRY_LIMIT) ? ST_BRAKE_R : ST_HALT;
                end
                ST_BRAKE_R: begin
                    if (timer_q == DEAD_CYC - 1) begin
                        state_d = ST_REVERSE;
                        retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
                    end
                end
                ST_REVERSE: begin
                    mode_d = MODE_REV;
                    if (line_present || timer_q == REV_CYC - 1) state_d = ST_BRAKE_F;
                end
                ST_BRAKE_F: begin
                    if (timer_q == DEAD_CYC - 1) state_d = line_present ? ST_FOLLOW : ST_SEARCH;
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state, shared timer (cleared on every state change) and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            retry_q     <= '0;
            last_turn_q <= MODE_LEFT;
            mode_q      <= MODE_STOP;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= (state_d != state_q) ? '0 : timer_q + 32'd1;
            retry_q     <= retry_d;
            last_turn_q <= last_turn_d;
            mode_q      <= mode_d;
            halted_q    <= (state_d == ST_HALT);
        end
    end

    assign mode   = mode_q;
    assign state  = state_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_kart_drive_ctrl.sv
// Scoreboarded bench for kart_drive_ctrl: directed scenarios followed by
// random sensor/enable/reset traffic, checked against a behavioural model.
module tb_kart_drive_ctrl;

    localparam int DEB    = 4;
    localparam int DEAD   = 8;
    localparam int SEARCH = 16;
    localparam int REV    = 12;
    localparam int MAXR   = 2;

    localparam int S_IDLE = 0, S_FOLLOW = 1, S_SEARCH = 2, S_BRAKE_R = 3,
                   S_REVERSE = 4, S_BRAKE_F = 5, S_HALT = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] sensor = 3'b000;
    logic [2:0] mode;
    logic [2:0] state;
    logic       halted;

    int total = 0;
    int bad   = 0;

    kart_drive_ctrl #(
        .DEB_CYC    (DEB),
        .DEAD_CYC   (DEAD),
        .SEARCH_CYC (SEARCH),
        .REV_CYC    (REV),
        .MAX_RETRY  (MAXR)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .sensor (sensor),
        .mode   (mode),
        .state  (state),
        .halted (halted)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    logic [6:0] exp_q [$];      // {mode, state, halted}
    logic [2:0] m_rawq [$];     // two-cycle synchroniser delay line
    logic [2:0] m_win  [$];     // last DEB synchronised samples
    logic [2:0] m_filt;
    logic [2:0] m_lt;
    int         m_st, m_cyc, m_retry;

    function automatic logic [2:0] model_decode(input logic [2:0] f);
        logic l, r;
        l = f[2];
        r = f[0];
        if (f == 3'b000) return 3'b000;
        if (l == r)      return 3'b001;
        if (l)           return 3'b010;
        return 3'b011;
    endfunction

    task automatic model_step(input logic r, input logic en, input logic [2:0] raw);
        logic [2:0] dec, e_mode, s, drop;
        logic       present, flip;
        int         n, nxt;
        if (r) begin
            m_st = S_IDLE; m_cyc = 0; m_retry = 0; m_lt = 3'b010; m_filt = 3'b000;
            m_rawq.delete(); m_rawq.push_back(3'b000); m_rawq.push_back(3'b000);
            m_win.delete();
            exp_q.push_back({3'b000, 3'(S_IDLE), 1'b0});
            return;
        end
        present = (m_filt != 3'b000);
        dec     = model_decode(m_filt);
        n       = m_cyc + 1;
        nxt     = m_st;
        e_mode  = 3'b000;
        if (!en) begin
            nxt = S_IDLE;
            m_retry = 0;
        end else begin
            case (m_st)
                S_IDLE:   nxt = S_FOLLOW;
                S_FOLLOW: begin
                    e_mode = dec;
                    if (present) m_retry = 0;
                    if (dec == 3'b010 || dec == 3'b011) m_lt = dec;
                    if (!present) nxt = S_SEARCH;
                end
                S_SEARCH: begin
                    e_mode = m_lt;
                    if (present) nxt = S_FOLLOW;
                    else if (n == SEARCH) nxt = (m_retry < MAXR) ? S_BRAKE_R : S_HALT;
                end
                S_BRAKE_R: if (n == DEAD) begin nxt = S_REVERSE; m_retry++; end
                S_REVERSE: begin
                    e_mode = 3'b101;
                    if (present || n == REV) nxt = S_BRAKE_F;
                end
                S_BRAKE_F: if (n == DEAD) nxt = present ? S_FOLLOW : S_SEARCH;
                default: ;
            endcase
        end
        m_cyc = (nxt != m_st) ? 0 : n;
        m_st  = nxt;
        exp_q.push_back({e_mode, 3'(m_st), (m_st == S_HALT)});
        s = m_rawq.pop_front();
        m_rawq.push_back(raw);
        m_win.push_back(s);
        if (m_win.size() > DEB) drop = m_win.pop_front();
        if (m_win.size() == DEB) begin
            for (int b = 0; b < 3; b++) begin
                flip = 1'b1;
                for (int k = 0; k < DEB; k++) if (m_win[k][b] == m_filt[b]) flip = 1'b0;
                if (flip) m_filt[b] = ~m_filt[b];
            end
        end
    endtask

    always @(posedge clk) model_step(rst, enable, sensor);

    // ---------------- monitor: scoreboard + dead-time checker ----------------
    int   zero_run = 0;
    logic have_last = 1'b0;
    logic last_b2 = 1'b0;

    always @(negedge clk) begin
        logic [6:0] e;
        if (rst) begin
            total++;
            if (mode !== 3'b000 || state !== 3'(S_IDLE) || halted !== 1'b0) begin
                bad++;
                $display("FAIL reset_values: mode=%b state=%0d halted=%b want 000/0/0", mode, state, halted);
            end
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if ({mode, state, halted} !== e) begin
                bad++;
                $display("FAIL scoreboard @%0t: mode=%b state=%0d halted=%b want mode=%b state=%0d halted=%b",
                         $time, mode, state, halted, e[6:4], e[3:1], e[0]);
            end
        end
        if (mode == 3'b000) begin
            zero_run++;
        end else begin
            if (have_last && mode[2] != last_b2) begin
                total++;
                if (zero_run < DEAD) begin
                    bad++;
                    $display("FAIL deadtime @%0t: only %0d stop cycles before mode %b, want >= %0d",
                             $time, zero_run, mode, DEAD);
                end
            end
            have_last = 1'b1;
            last_b2   = mode[2];
            zero_run  = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        int found;
        tick(4);
        // 1: start-up and basic decode
        rst = 1'b0; enable = 1'b1; sensor = 3'b010;
        found = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (mode == 3'b001) begin found = 1; break; end
        end
        check("fwd_latency", found, 1);
        tick(4);
        sensor = 3'b110; tick(10); check("left_mode", mode, 3'b010);
        sensor = 3'b011; tick(10); check("right_mode", mode, 3'b011);
        // 2: short glitch is filtered
        sensor = 3'b010; tick(10);
        sensor = 3'b000; tick(3);
        sensor = 3'b010; tick(10);
        check("glitch_mode", mode, 3'b001);
        check("glitch_state", state, S_FOLLOW);
        // 3/4: lost after right turn, line returns during reverse
        sensor = 3'b011; tick(10);
        sensor = 3'b000; tick(12);
        check("search_dir", mode, 3'b011);
        tick(22);
        check("reverse_mode", mode, 3'b101);
        check("reverse_state", state, S_REVERSE);
        sensor = 3'b010; tick(30);
        check("recover_mode", mode, 3'b001);
        check("recover_state", state, S_FOLLOW);
        // 5: line never returns -> HALT, then enable toggle
        sensor = 3'b011; tick(10);
        sensor = 3'b000; tick(200);
        check("halt_flag", halted, 1);
        check("halt_mode", mode, 3'b000);
        check("halt_state", state, S_HALT);
        enable = 1'b0; tick(12);
        check("disable_state", state, S_IDLE);
        enable = 1'b1; tick(1);
        check("reenable_state", state, S_FOLLOW);
        sensor = 3'b010; tick(15);
        // 6: reset during REVERSE
        sensor = 3'b000;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (state == 3'(S_REVERSE)) begin found = 1; break; end
        end
        check("reach_reverse", found, 1);
        tick(2);
        rst = 1'b1; #1;
        check("rst_async_mode", mode, 3'b000);
        check("rst_async_state", state, S_IDLE);
        tick(10);
        rst = 1'b0; sensor = 3'b010; tick(20);
        check("post_rst_mode", mode, 3'b001);
        // random traffic
        for (int it = 0; it < 250; it++) begin
            int unsigned act;
            act = $urandom_range(0, 99);
            if (act < 4) begin
                rst = 1'b1; tick($urandom_range(9, 12)); rst = 1'b0;
            end else if (act < 9) begin
                enable = 1'b0; tick($urandom_range(10, 20)); enable = 1'b1;
            end else if (act < 20) begin
                sensor = 3'b000; tick($urandom_range(20, 160));
            end else begin
                sensor = 3'($urandom_range(0, 7)); tick($urandom_range(1, 30));
            end
        end
        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
